gshare_bht: RTL and testbench
=============================

// Module: gshare_bht
// PURPOSE
// Parametrised gshare branch history table: per-entry saturating counters indexed by
//   PC index XOR global history register (GHR). Sits in the fetch stage (prediction)
//   and is trained from the branch-resolve stage (update). Maintains a speculative GHR
//   with misprediction recovery; counters are initialised by a post-reset sweep FSM.
// PARAMETERS
// IDX_W   10  table index width; N_SETS = 2**IDX_W entries
// CTR_W   2   counter width, >= 2; prediction = counter MSB
// HIST_W  8   GHR length, 1..IDX_W; zero-extended to IDX_W before XOR
// PORTS
// clk            in   1        clock, all state on posedge
// rst_n          in   1        asynchronous active-low reset
// pred_valid     in   1        fetch requests a prediction this cycle
// pred_idx       in   IDX_W    PC-derived index of fetched branch
// pred_taken     out  1        prediction (combinational from table/bypass)
// pred_hist      out  HIST_W   GHR value used for this prediction; carried down the pipe
// upd_valid      in   1        resolved branch update this cycle
// upd_idx        in   IDX_W    PC-derived index of resolved branch
// upd_hist       in   HIST_W   pred_hist captured when the branch was predicted
// upd_taken      in   1        actual outcome
// upd_mispredict in   1        outcome differed from prediction
// init_busy      out  1        init sweep in progress
// stat_lookups   out  32       prediction count (BHT_STATS_EN only)
// stat_mispred   out  32       mispredict count (BHT_STATS_EN only)
// BEHAVIOUR
// - Reset (async): GHR=0, FSM=INIT, sweep ptr=0, init_busy=1, stats=0.
// - FSM INIT: write entry[ptr] = weakly-taken ({1'b1,{CTR_W-1{0}}}), ptr++ per cycle;
//   after ptr = N_SETS-1 is written -> READY, init_busy=0 next cycle. INIT takes N_SETS cycles.
// - INIT: pred_taken=0, pred_hist=GHR, GHR frozen, upd_valid ignored (no write, no recovery).
// - READY: r_ix = pred_idx ^ GHR; pred_taken = table[r_ix][CTR_W-1], same cycle, no latency.
// - Update: w_ix = upd_idx ^ upd_hist; taken -> +1 saturating at all-ones;
//   not-taken -> -1 saturating at 0; written at posedge. One write per cycle.
// - Bypass: upd_valid && r_ix==w_ix same cycle -> pred_taken = MSB of post-update counter.
// - GHR: pred_valid -> GHR <= {GHR[HIST_W-2:0], pred_taken} (HIST_W=1: GHR <= pred_taken).
// - Recovery: upd_valid && upd_mispredict -> GHR <= {upd_hist[HIST_W-2:0], upd_taken};
//   wins over a simultaneous pred_valid shift (that prediction is on the wrong path).
// - upd_valid without mispredict never touches GHR.
// - rst_n low mid-sweep or mid-operation restarts INIT from ptr=0; table contents are not
//   trusted until init_busy falls.
// - Indices wrap modulo N_SETS by construction (XOR of IDX_W-bit values).
// CONFIGURATION
// BHT_STATS_EN defined: stat_lookups++ per READY cycle with pred_valid; stat_mispred++ per
//   READY cycle with upd_valid && upd_mispredict; both wrap at 2**32, cleared by reset only.
// BHT_STATS_EN undefined: no counters; stat_* ports present and tied to 0.
// TESTING
// 1 Reset, IDX_W=4: init_busy=1 exactly 16 cycles; then every index predicts taken, GHR=0.
// 2 upd idx=3 hist=0 not-taken x2 -> pred idx=3 (GHR=0) gives 0; x3 more -> counter stays 0.
// 3 upd idx=3 hist=0 taken x5 from 2'b00 -> counter saturates at 2'b11; pred_taken=1.
// 4 pred_valid x3 with taken,taken,not-taken -> GHR=8'b0000_0110; pred_idx=5 reads entry 5^6=3.
// 5 Same cycle: pred_valid=1 and upd_mispredict=1, upd_hist=8'h0F, upd_taken=0 -> GHR=8'h1E.
// 6 Same cycle update/predict to same w_ix/r_ix, counter 2'b01, upd_taken=1 -> pred_taken=1.

Source files
------------

// File: rtl/gshare_bht_if.sv
// Prediction and update port bundle for the gshare branch history table.
// master = fetch/resolve side, slave = the predictor.
interface gshare_bht_if #(
  parameter int IDX_W  = 10,
  parameter int HIST_W = 8
);
  logic              pred_valid;
  logic [IDX_W-1:0]  pred_idx;
  logic              pred_taken;
  logic [HIST_W-1:0] pred_hist;
  logic              upd_valid;
  logic [IDX_W-1:0]  upd_idx;
  logic [HIST_W-1:0] upd_hist;
  logic              upd_taken;
  logic              upd_mispredict;

  modport master (
    output pred_valid, pred_idx, upd_valid, upd_idx, upd_hist, upd_taken, upd_mispredict,
    input  pred_taken, pred_hist
  );

  modport slave (
    input  pred_valid, pred_idx, upd_valid, upd_idx, upd_hist, upd_taken, upd_mispredict,
    output pred_taken, pred_hist
  );
endinterface

// File: rtl/gshare_bht.sv
// gshare branch predictor: saturating counters indexed by pc_idx ^ GHR, speculative GHR
// with mispredict recovery, post-reset init sweep. Optional counters via BHT_STATS_EN.
module gshare_bht #(
  parameter int IDX_W  = 10,
  parameter int CTR_W  = 2,
  parameter int HIST_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  gshare_bht_if.slave  bus,
  output logic         init_busy,
  output logic [31:0]  stat_lookups,
  output logic [31:0]  stat_mispred
);
  localparam int N_SETS = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX   = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WEAK  = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [IDX_W-1:0] PTR_LAST  = IDX_W'(N_SETS - 1);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t            state_reg;
  logic [IDX_W-1:0]  ptr_reg;
  logic [HIST_W-1:0] ghr_reg;
  logic [HIST_W-1:0] ghr_shift;
  logic [HIST_W-1:0] ghr_recover;
  logic [CTR_W-1:0]  table_mem [N_SETS];

  logic              ready;
  logic [IDX_W-1:0]  r_ix;
  logic [IDX_W-1:0]  w_ix;
  logic [CTR_W-1:0]  upd_ctr_cur;
  logic [CTR_W-1:0]  upd_ctr_next;
  logic              pred_taken_comb;

  assign ready       = (state_reg == ST_READY);
  assign r_ix        = bus.pred_idx ^ IDX_W'(ghr_reg);
  assign w_ix        = bus.upd_idx ^ IDX_W'(bus.upd_hist);
  assign upd_ctr_cur = table_mem[w_ix];

  always_comb begin
    upd_ctr_next = upd_ctr_cur;
    if (bus.upd_taken) begin
      if (upd_ctr_cur != CTR_MAX) upd_ctr_next = upd_ctr_cur + CTR_W'(1);
    end else begin
      if (upd_ctr_cur != '0) upd_ctr_next = upd_ctr_cur - CTR_W'(1);
    end
  end

  // Same-cycle update to the entry being read forwards the post-update counter.
  always_comb begin
    pred_taken_comb = 1'b0;
    if (ready) begin
      if (bus.upd_valid && (r_ix == w_ix)) pred_taken_comb = upd_ctr_next[CTR_W-1];
      else                                 pred_taken_comb = table_mem[r_ix][CTR_W-1];
    end
  end

  assign bus.pred_taken = pred_taken_comb;
  assign bus.pred_hist  = ghr_reg;

  generate
    if (HIST_W == 1) begin : g_hist1
      assign ghr_shift   = pred_taken_comb;
      assign ghr_recover = bus.upd_taken;
    end else begin : g_histn
      assign ghr_shift   = {ghr_reg[HIST_W-2:0], pred_taken_comb};
      assign ghr_recover = {bus.upd_hist[HIST_W-2:0], bus.upd_taken};
    end
  endgenerate

  // Single write port: the init sweep owns it until READY.
  always_ff @(posedge clk) begin
    if (!ready)             table_mem[ptr_reg] <= CTR_WEAK;
    else if (bus.upd_valid) table_mem[w_ix]    <= upd_ctr_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_INIT;
      ptr_reg   <= '0;
      init_busy <= 1'b1;
      ghr_reg   <= '0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          ptr_reg <= ptr_reg + IDX_W'(1);
          if (ptr_reg == PTR_LAST) begin
            state_reg <= ST_READY;
            init_busy <= 1'b0;
          end
        end
        ST_READY: begin
          // Recovery beats the shift: that prediction was on the wrong path.
          if (bus.upd_valid && bus.upd_mispredict) ghr_reg <= ghr_recover;
          else if (bus.pred_valid)                 ghr_reg <= ghr_shift;
        end
        default: state_reg <= ST_INIT;
      endcase
    end
  end

`ifdef BHT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups <= '0;
      stat_mispred <= '0;
    end else if (ready) begin
      if (bus.pred_valid)                      stat_lookups <= stat_lookups + 32'd1;
      if (bus.upd_valid && bus.upd_mispredict) stat_mispred <= stat_mispred + 32'd1;
    end
  end
`else
  assign stat_lookups = '0;
  assign stat_mispred = '0;
`endif
endmodule

// File: tb/tb_gshare_bht.sv
// Directed bench for gshare_bht (IDX_W=4, CTR_W=2, HIST_W=4): vector table plus
// hand-written reset / init-sweep sequences.
module tb_gshare_bht;
  localparam int IDX_W  = 4;
  localparam int CTR_W  = 2;
  localparam int HIST_W = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_busy;
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispred;

  gshare_bht_if #(.IDX_W(IDX_W), .HIST_W(HIST_W)) bus ();

  gshare_bht #(.IDX_W(IDX_W), .CTR_W(CTR_W), .HIST_W(HIST_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .init_busy    (init_busy),
    .stat_lookups (stat_lookups),
    .stat_mispred (stat_mispred)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pv;
    logic [3:0] pidx;
    logic       uv;
    logic [3:0] uidx;
    logic [3:0] uhist;
    logic       ut;
    logic       um;
    logic       exp_t;
    logic [3:0] exp_h;
  } vec_t;

  localparam int N_VEC = 28;
  vec_t vecs [N_VEC];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic drive_idle();
    bus.pred_valid     = 1'b0;
    bus.pred_idx       = '0;
    bus.upd_valid      = 1'b0;
    bus.upd_idx        = '0;
    bus.upd_hist       = '0;
    bus.upd_taken      = 1'b0;
    bus.upd_mispredict = 1'b0;
  endtask

  // Counts posedges until init_busy falls; caller must be between edges.
  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (!init_busy) break;
    end
    check(name, n, 16);
  endtask

  initial begin
    // pv pidx uv uidx uhist ut um exp_t exp_h
    vecs[0]  = '{0, 4'd3, 1, 4'd3, 4'h0, 0, 0, 0, 4'h0};
    vecs[1]  = '{0, 4'd3, 1, 4'd3, 4'h0, 0, 0, 0, 4'h0};
    vecs[2]  = '{0, 4'd3, 0, 4'd0, 4'h0, 0, 0, 0, 4'h0};
    vecs[3]  = '{0, 4'd3, 1, 4'd3, 4'h0, 0, 0, 0, 4'h0};
    vecs[4]  = '{0, 4'd3, 1, 4'd3, 4'h0, 0, 0, 0, 4'h0};
    vecs[5]  = '{0, 4'd3, 1, 4'd3, 4'h0, 0, 0, 0, 4'h0};
    vecs[6]  = '{0, 4'd3, 0, 4'd0, 4'h0, 0, 0, 0, 4'h0};
    vecs[7]  = '{0, 4'd3, 1, 4'd3, 4'h0, 1, 0, 0, 4'h0};
    vecs[8]  = '{0, 4'd3, 1, 4'd3, 4'h0, 1, 0, 1, 4'h0};
    vecs[9]  = '{0, 4'd3, 1, 4'd3, 4'h0, 1, 0, 1, 4'h0};
    vecs[10] = '{0, 4'd3, 1, 4'd3, 4'h0, 1, 0, 1, 4'h0};
    vecs[11] = '{0, 4'd3, 1, 4'd3, 4'h0, 1, 0, 1, 4'h0};
    vecs[12] = '{0, 4'd3, 0, 4'd0, 4'h0, 0, 0, 1, 4'h0};
    vecs[13] = '{0, 4'd3, 1, 4'd3, 4'h0, 0, 0, 1, 4'h0};
    vecs[14] = '{0, 4'd3, 1, 4'd3, 4'h0, 0, 0, 0, 4'h0};
    vecs[15] = '{1, 4'd5, 0, 4'd0, 4'h0, 0, 0, 1, 4'h0};
    vecs[16] = '{1, 4'd0, 0, 4'd0, 4'h0, 0, 0, 1, 4'h1};
    vecs[17] = '{1, 4'd0, 0, 4'd0, 4'h0, 0, 0, 0, 4'h3};
    vecs[18] = '{0, 4'd5, 0, 4'd0, 4'h0, 0, 0, 0, 4'h6};
    vecs[19] = '{1, 4'd0, 1, 4'd0, 4'hF, 0, 1, 1, 4'h6};
    vecs[20] = '{0, 4'd0, 0, 4'd0, 4'h0, 0, 0, 1, 4'hE};
    vecs[21] = '{0, 4'd2, 1, 4'd0, 4'h0, 1, 0, 1, 4'hE};
    vecs[22] = '{0, 4'd0, 0, 4'd0, 4'h0, 0, 0, 1, 4'hE};
    vecs[23] = '{0, 4'd1, 1, 4'd0, 4'hF, 1, 0, 1, 4'hE};
    vecs[24] = '{0, 4'd1, 0, 4'd0, 4'h0, 0, 0, 1, 4'hE};
    vecs[25] = '{0, 4'd0, 1, 4'd3, 4'h3, 1, 1, 1, 4'hE};
    vecs[26] = '{0, 4'd7, 0, 4'd0, 4'h0, 0, 0, 1, 4'h7};
    vecs[27] = '{0, 4'd4, 0, 4'd0, 4'h0, 0, 0, 0, 4'h7};

    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_init_busy", {31'd0, init_busy}, 1);
    check("reset_pred_hist", {28'd0, bus.pred_hist}, 0);
    check("reset_pred_taken", {31'd0, bus.pred_taken}, 0);

    @(negedge clk);
    rst_n = 1'b1;
    count_busy("init_cycles");

    for (int i = 0; i < 16; i++) begin
      bus.pred_idx = 4'(i);
      #1;
      check($sformatf("post_init_taken_%0d", i), {31'd0, bus.pred_taken}, 1);
    end
    check("post_init_ghr", {28'd0, bus.pred_hist}, 0);

    for (int i = 0; i < N_VEC; i++) begin
      bus.pred_valid     = vecs[i].pv;
      bus.pred_idx       = vecs[i].pidx;
      bus.upd_valid      = vecs[i].uv;
      bus.upd_idx        = vecs[i].uidx;
      bus.upd_hist       = vecs[i].uhist;
      bus.upd_taken      = vecs[i].ut;
      bus.upd_mispredict = vecs[i].um;
      @(negedge clk);
      $display("vec %0d: pred_taken=%0d pred_hist=%0h", i, bus.pred_taken, bus.pred_hist);
      check($sformatf("vec%0d_taken", i), {31'd0, bus.pred_taken}, {31'd0, vecs[i].exp_t});
      check($sformatf("vec%0d_hist", i), {28'd0, bus.pred_hist}, {28'd0, vecs[i].exp_h});
      @(posedge clk);
      #1;
    end

    // Reset mid-operation: GHR cleared, sweep restarts, inputs ignored during INIT.
    drive_idle();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, init_busy}, 1);
    check("midrst_hist", {28'd0, bus.pred_hist}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.pred_valid     = 1'b1;
    bus.pred_idx       = 4'd3;
    bus.upd_valid      = 1'b1;
    bus.upd_idx        = 4'd5;
    bus.upd_hist       = 4'h0;
    bus.upd_taken      = 1'b0;
    bus.upd_mispredict = 1'b1;
    #1;
    check("init_pred_taken", {31'd0, bus.pred_taken}, 0);
    count_busy("reinit_cycles");
    drive_idle();
    #1;
    check("reinit_ghr_frozen", {28'd0, bus.pred_hist}, 0);
    bus.pred_idx = 4'd3;
    #1;
    check("reinit_entry3", {31'd0, bus.pred_taken}, 1);
    bus.pred_idx = 4'd5;
    #1;
    check("reinit_entry5", {31'd0, bus.pred_taken}, 1);

`ifndef BHT_STATS_EN
    check("stat_lookups_tied", stat_lookups, 0);
    check("stat_mispred_tied", stat_mispred, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
